// File: rtl/mem_bus_pkg.sv
// Shared owner encoding and request-field bundle for the memory-bus arbiter.
package mem_bus_pkg;
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;
    localparam int   REQ_W      = 71;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_fields_t;
endpackage

// File: rtl/owner_fifo.sv
// In-order record of which requester owns each outstanding transaction.
module owner_fifo #(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [DEPTH-1:0] slots;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates inst/data requesters onto one sram-like port and routes in-order returns to their owner.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_OUTST   = 2,
    parameter int DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        err_orphan
);
    localparam int SW = $clog2(DATA_STREAK + 1);
    localparam int CW = $clog2(MAX_OUTST + 1);

    req_fields_t   inst_f, data_f, sel_f;
    logic          sel, sel_req, accept;
    logic          lock, lock_owner;
    logic [SW-1:0] streak;
    logic          streak_max;
    logic          head, full, empty, ret_ok;
    logic [CW-1:0] outst;

    assign inst_f = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
    assign data_f = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

    assign streak_max = (streak == SW'(DATA_STREAK));

    // A stalled downstream request keeps its owner so mem_* never changes under the slave.
    always_comb begin
        sel = OWNER_INST;
        if (lock)
            sel = lock_owner;
        else if (data_req && !(inst_req && streak_max))
            sel = OWNER_DATA;
    end

    assign sel_req = (sel == OWNER_DATA) ? data_req : inst_req;
    assign mem_req = sel_req & ~full & ~reset;
    assign accept  = mem_req & mem_addr_ok;
    assign sel_f   = (sel == OWNER_DATA) ? data_f : inst_f;

    assign mem_wr    = sel_f.wr;
    assign mem_size  = sel_f.size;
    assign mem_addr  = sel_f.addr;
    assign mem_wstrb = sel_f.wstrb;
    assign mem_wdata = sel_f.wdata;

    assign inst_addr_ok = accept & (sel == OWNER_INST);
    assign data_addr_ok = accept & (sel == OWNER_DATA);

    assign ret_ok       = mem_data_ok & ~empty & ~reset;
    assign inst_data_ok = ret_ok & (head == OWNER_INST);
    assign data_data_ok = ret_ok & (head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    owner_fifo #(.DEPTH(MAX_OUTST)) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (sel),
        .pop   (ret_ok),
        .dout  (head),
        .count (outst),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lock       <= 1'b0;
            lock_owner <= OWNER_INST;
            streak     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (mem_req && !mem_addr_ok) begin
                lock       <= 1'b1;
                lock_owner <= sel;
            end else if (mem_addr_ok) begin
                lock <= 1'b0;
            end

            // Bound inst starvation: after DATA_STREAK data wins, inst gets one forced grant.
            if (!inst_req || inst_addr_ok)
                streak <= '0;
            else if (data_addr_ok && !streak_max)
                streak <= streak + SW'(1);

            if (mem_data_ok && outst == '0)
                err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked every cycle against a queue-based reference model.
module tb_mem_bus_arbiter;
    localparam int MAX_OUTST   = 2;
    localparam int DATA_STREAK = 4;

    logic        clk, reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_orphan;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .DATA_STREAK(DATA_STREAK)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: queue of owners of accepted transactions, the owner of a
    // presented-but-unaccepted request, consecutive-data-win count, sticky orphan flag.
    bit oq[$];
    bit pend, pend_own, err_m;
    int streak_m;
    bit m_iacc, m_dacc;

    task automatic model_cycle();
        bit have, own, e_req, e_iao, e_dao, e_ido, e_ddo, popping;
        if (reset) begin
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
            chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
            chk("err_orphan", 32'(err_orphan), 32'(err_m));
            oq.delete();
            pend = 0; streak_m = 0; err_m = 0; m_iacc = 0; m_dacc = 0;
        end else begin
            have = 1; own = 0;
            if (pend) own = pend_own;
            else if (data_req && !(inst_req && streak_m >= DATA_STREAK)) own = 1;
            else if (inst_req) own = 0;
            else have = 0;
            e_req   = have && (own ? data_req : inst_req) && (oq.size() < MAX_OUTST);
            e_iao   = e_req && mem_addr_ok && !own;
            e_dao   = e_req && mem_addr_ok && own;
            popping = mem_data_ok && (oq.size() > 0);
            e_ido   = popping && (oq[0] == 1'b0);
            e_ddo   = popping && (oq[0] == 1'b1);

            chk("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                chk("mem_addr", mem_addr, own ? data_addr : inst_addr);
                chk("mem_wdata", mem_wdata, own ? data_wdata : inst_wdata);
                chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
                    own ? {25'd0, data_wr, data_size, data_wstrb} : {25'd0, inst_wr, inst_size, inst_wstrb});
            end
            chk("addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, e_iao, e_dao});
            chk("data_ok", {30'd0, inst_data_ok, data_data_ok}, {30'd0, e_ido, e_ddo});
            if (e_ido) chk("inst_rdata", inst_rdata, mem_rdata);
            if (e_ddo) chk("data_rdata", data_rdata, mem_rdata);
            chk("err_orphan", 32'(err_orphan), 32'(err_m));

            if (mem_data_ok && oq.size() == 0) err_m = 1;
            if (popping) void'(oq.pop_front());
            if (e_req && mem_addr_ok) oq.push_back(own);
            pend     = e_req && !mem_addr_ok;
            pend_own = own;
            if (!inst_req || e_iao) streak_m = 0;
            else if (e_dao && streak_m < DATA_STREAK) streak_m++;
            m_iacc = e_iao;
            m_dacc = e_dao;
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inst();
        inst_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 3));
        inst_addr  = $urandom;
        inst_wstrb = 4'($urandom_range(0, 15));
        inst_wdata = $urandom;
    endtask

    task automatic rand_data();
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 3));
        data_addr  = $urandom;
        data_wstrb = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
    endtask

    logic [9:0] pat;

    initial begin
        reset = 1; inst_req = 1; data_req = 1;
        rand_inst(); rand_data();
        inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

        // 1: reset held with both requests pending
        repeat (2) begin
            @(negedge clk);
            chk("t1_mem_req", 32'(mem_req), 0);
            chk("t1_err", 32'(err_orphan), 0);
        end

        // 2: data wins first, inst next, returns routed in order
        step(); reset = 0; mem_addr_ok = 1;
        @(negedge clk);
        chk("t2_addr_d", mem_addr, 32'h0000_2000);
        chk("t2_dao", 32'(data_addr_ok), 1);
        step(); data_req = 0;
        @(negedge clk);
        chk("t2_addr_i", mem_addr, 32'h0000_1000);
        chk("t2_iao", 32'(inst_addr_ok), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("t2_ddo", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        chk("t2_drdata", data_rdata, 32'h1111_1111);
        step(); mem_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("t2_ido", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        chk("t2_irdata", inst_rdata, 32'h2222_2222);
        step(); mem_data_ok = 0;

        // 3: stalled inst request stays on the bus when data arrives
        inst_req = 1; inst_addr = 32'h0000_3000; data_addr = 32'h0000_4000;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) data_req = 1;
            @(negedge clk);
            chk("t3_hold", mem_addr, 32'h0000_3000);
            step();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        chk("t3_iao", 32'(inst_addr_ok), 1);
        step(); inst_req = 0;
        @(negedge clk);
        chk("t3_dao", 32'(data_addr_ok), 1);
        chk("t3_addr_d", mem_addr, 32'h0000_4000);
        step(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        step(); step(); mem_data_ok = 0;

        // 4: full FIFO blocks the request even while a return pops
        inst_req = 1; mem_addr_ok = 1;
        step(); step();
        mem_data_ok = 1;
        @(negedge clk);
        chk("t4_full", 32'(mem_req), 0);
        step(); mem_data_ok = 0;
        @(negedge clk);
        chk("t4_reopen", 32'(mem_req), 1);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        chk("t4_ido", 32'(inst_data_ok), 1);
        step(); step(); mem_data_ok = 0;

        // 5: streak fairness pattern, 1=data grant
        pat = 10'b1111011110;
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_grant_d", 32'(data_addr_ok), 32'(pat[9-k]));
            chk("t5_grant_i", 32'(inst_addr_ok), 32'(!pat[9-k]));
            step(); mem_data_ok = 1;
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        step(); mem_data_ok = 0;

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            step();
            if (i == 700) reset = 1;
            if (i == 702) reset = 0;
            if (!inst_req || m_iacc) begin inst_req = ($urandom_range(0, 3) != 0); rand_inst(); end
            if (!data_req || m_dacc) begin data_req = ($urandom_range(0, 3) != 0); rand_data(); end
            mem_addr_ok = ($urandom_range(0, 9) < 6);
            mem_data_ok = (oq.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;
        end
        step(); reset = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        step(); step(); reset = 0;

        // 6: orphan return is flagged and sticks until reset
        mem_data_ok = 1;
        @(negedge clk);
        chk("t6_no_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        step(); mem_data_ok = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_sticky", 32'(err_orphan), 1);
            step();
        end
        reset = 1;
        step(); reset = 0;
        @(negedge clk);
        chk("t6_cleared", 32'(err_orphan), 0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
